// File: rtl/adau1761_i2s_xcvr.sv
// adau1761_i2s_xcvr: I2S master transceiver between the adau1761_data register block and the codec
module adau1761_i2s_xcvr #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] tx_left,
  input  logic [DATA_WIDTH-1:0] tx_right,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_left,
  output logic [DATA_WIDTH-1:0] rx_right,
  output logic                  rx_valid,
  output logic [15:0]           underrun_cnt,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata_out,
  input  logic                  sdata_in
);
  localparam int DCW = $clog2(BCLK_DIV);
  localparam int BCW = $clog2(2*SLOT_WIDTH);
  localparam logic [DCW-1:0] DIV_TC = DCW'(BCLK_DIV-1);
  localparam logic [BCW-1:0] SLOT = BCW'(SLOT_WIDTH);
  localparam logic [BCW-1:0] LAST = BCW'(2*SLOT_WIDTH-1);
  localparam logic [BCW-1:0] DBITS = BCW'(DATA_WIDTH);
  logic [DCW-1:0] div_cnt;
  logic [BCW-1:0] bit_cnt, bit_nxt, p_cur, p_nxt;
  logic [DATA_WIDTH-1:0] hold_l, hold_r, act_l, act_r, sh_l, sh_r, word_nxt;
  logic hold_full, run, rx_pend, tc, rise, fall, frame_start, lr_nxt, sd_nxt;
  assign tx_ready = !hold_full;
  assign lrclk = bit_cnt >= SLOT;
  always_comb begin
    tc = enable && div_cnt == DIV_TC;
    rise = tc && !bclk;
    fall = tc && bclk;
    bit_nxt = bit_cnt == LAST ? '0 : bit_cnt + BCW'(1);
    frame_start = enable && (!run || (fall && bit_nxt == '0));
    lr_nxt = bit_nxt >= SLOT;
    p_cur = lrclk ? bit_cnt - SLOT : bit_cnt;
    p_nxt = lr_nxt ? bit_nxt - SLOT : bit_nxt;
    // slot bit p carries sample bit DATA_WIDTH-p, so the MSB lands one BCLK after the LRCLK edge
    word_nxt = (lr_nxt ? act_r : act_l) >> (DATA_WIDTH - int'(p_nxt));
    sd_nxt = p_nxt != '0 && p_nxt <= DBITS && word_nxt[0];
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk <= 1'b0;
      sdata_out <= 1'b0;
      run <= 1'b0;
      hold_full <= 1'b0;
      hold_l <= '0;
      hold_r <= '0;
      act_l <= '0;
      act_r <= '0;
      sh_l <= '0;
      sh_r <= '0;
      rx_pend <= 1'b0;
      rx_left <= '0;
      rx_right <= '0;
      rx_valid <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      run <= enable;
      rx_valid <= 1'b0;
      if (tx_valid && !hold_full) begin
        hold_l <= tx_left;
        hold_r <= tx_right;
        hold_full <= 1'b1;
      end
      if (!enable) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        bclk <= 1'b0;
        sdata_out <= 1'b0;
        act_l <= '0;
        act_r <= '0;
        sh_l <= '0;
        sh_r <= '0;
        rx_pend <= 1'b0;
      end else begin
        div_cnt <= tc ? '0 : div_cnt + DCW'(1);
        if (tc) bclk <= !bclk;
        if (fall) begin
          bit_cnt <= bit_nxt;
          sdata_out <= sd_nxt;
        end
        if (frame_start) begin
          act_l <= hold_full ? hold_l : '0;
          act_r <= hold_full ? hold_r : '0;
          if (hold_full) hold_full <= 1'b0;
          else if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
        end
        if (rise && p_cur != '0 && p_cur <= DBITS) begin
          if (lrclk) sh_r <= {sh_r[DATA_WIDTH-2:0], sdata_in};
          else sh_l <= {sh_l[DATA_WIDTH-2:0], sdata_in};
        end
        rx_pend <= rise && lrclk && p_cur == DBITS;
        if (rx_pend) begin
          rx_left <= sh_l;
          rx_right <= sh_r;
          rx_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_adau1761_i2s_xcvr.sv
// tb_adau1761_i2s_xcvr: random and directed stimulus against a time-indexed model of the I2S link
module tb_adau1761_i2s_xcvr;
  localparam int DW = 24, SW = 32, D = 2;
  logic tb_ACLK = 0, ARESETN = 0, enable = 0, tx_valid = 0, sdata_in = 0, loop = 1;
  logic [DW-1:0] tx_left = '0, tx_right = '0, rx_left, rx_right;
  logic tx_ready, rx_valid, bclk, lrclk, sdata_out;
  logic [15:0] underrun_cnt;
  int n_chk = 0, n_fail = 0;
  adau1761_i2s_xcvr #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BCLK_DIV(D)) dut (
    .ACLK(tb_ACLK), .ARESETN(ARESETN), .enable(enable), .tx_left(tx_left), .tx_right(tx_right),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid),
    .underrun_cnt(underrun_cnt), .bclk(bclk), .lrclk(lrclk), .sdata_out(sdata_out), .sdata_in(sdata_in));
  always #5 tb_ACLK = !tb_ACLK;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: everything derives from k, the count of enabled edges since enable rose
  logic [DW-1:0] hl, hr, al, ar, cl, cr, m_rxl, m_rxr;
  logic [15:0] m_under;
  bit m_live = 0, m_full, m_run, pend, m_rxv, m_bclk, m_sdo, of, fs, tg, ri, fa;
  int k, t, p, m_bitc;
  always @(posedge tb_ACLK) begin
    m_live = 1;
    if (!ARESETN) begin
      {hl, hr, al, ar, cl, cr, m_rxl, m_rxr} = '0;
      {m_full, m_run, pend, m_rxv, m_bclk, m_sdo} = '0;
      m_under = 0; k = -1; m_bitc = 0;
    end else begin
      m_rxv = 0;
      if (enable && pend) begin m_rxl = cl; m_rxr = cr; m_rxv = 1; end
      pend = 0;
      of = m_full;
      if (tx_valid && !of) begin hl = tx_left; hr = tx_right; m_full = 1; end
      if (!enable) begin
        k = -1; m_bclk = 0; m_bitc = 0; m_sdo = 0; al = 0; ar = 0; cl = 0; cr = 0;
      end else begin
        k = m_run ? k + 1 : 0;
        tg = ((k + 1) % D) == 0;
        t = (k + 1) / D;
        m_bclk = t[0];
        ri = tg && m_bclk;
        fa = tg && !m_bclk;
        if (ri) begin
          p = m_bitc % SW;
          if (p >= 1 && p <= DW) begin
            if (m_bitc >= SW) cr[DW-p] = sdata_in; else cl[DW-p] = sdata_in;
          end
          pend = (m_bitc == SW + DW);
        end
        if (fa) m_bitc = (t / 2) % (2 * SW);
        fs = (k == 0) || (fa && m_bitc == 0);
        if (fs) begin
          if (of) begin al = hl; ar = hr; m_full = 0; end
          else begin al = 0; ar = 0; if (m_under != 16'hFFFF) m_under++; end
        end
        if (fa) begin
          p = m_bitc % SW;
          m_sdo = (p >= 1 && p <= DW) ? (m_bitc >= SW ? ar[DW-p] : al[DW-p]) : 1'b0;
        end
      end
      m_run = enable;
    end
  end
  always @(negedge tb_ACLK) if (m_live) begin
    chk("tx_ready", tx_ready, !m_full);
    chk("bclk", bclk, m_bclk);
    chk("lrclk", lrclk, m_bitc >= SW);
    chk("sdata_out", sdata_out, m_sdo);
    chk("rx_valid", rx_valid, m_rxv);
    chk("rx_left", rx_left, m_rxl);
    chk("rx_right", rx_right, m_rxr);
    chk("underrun_cnt", underrun_cnt, m_under);
  end
  always @(negedge tb_ACLK) sdata_in = loop ? sdata_out : 1'($urandom);
  task automatic cyc(input int n);
    repeat (n) @(negedge tb_ACLK);
  endtask
  task automatic wait_bit(input int b);
    int n = 0;
    while (m_bitc != b && n < 600) begin @(negedge tb_ACLK); n++; end
    if (n >= 600) chk("wait_bit_timeout", n, 0);
  endtask
  task automatic reset_checks();
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 0);
    chk("rst_sdata", sdata_out, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_left", rx_left, 0);
    chk("rst_rx_right", rx_right, 0);
    chk("rst_underrun", underrun_cnt, 0);
  endtask
  logic bits [64];
  logic lrs [64];
  logic [DW-1:0] wl, wr;
  int idx, first, second, ones, cnt;
  logic prev;
  initial begin
    cyc(5);
    reset_checks();
    ARESETN = 1;
    cyc(6);
    chk("idle_bclk", bclk, 0);
    tx_left = 24'hABCDEF; tx_right = 24'h123456; tx_valid = 1;
    cyc(1);
    tx_valid = 0;
    chk("ready_after_accept", tx_ready, 0);
    enable = 1;
    idx = 0; prev = 0; first = -1; second = -1;
    for (int i = 0; i < 256; i++) begin
      @(negedge tb_ACLK);
      if (bclk && !prev) begin
        if (first < 0) first = i; else if (second < 0) second = i;
        if (idx < 64) begin bits[idx] = sdata_out; lrs[idx] = lrclk; end
        idx++;
      end
      prev = bclk;
    end
    chk("rises_per_frame", idx, 64);
    chk("bclk_period", second - first, 4);
    wl = '0; wr = '0; ones = 0; cnt = 0;
    for (int q = 1; q <= DW; q++) begin wl[DW-q] = bits[q]; wr[DW-q] = bits[SW+q]; end
    for (int q = 0; q < 64; q++) begin
      if ((q % SW == 0 || q % SW > DW) && bits[q]) ones++;
      if (lrs[q] != (q >= SW)) cnt++;
    end
    chk("left_bits", wl, 24'hABCDEF);
    chk("right_bits", wr, 24'h123456);
    chk("pad_bits_zero", ones, 0);
    chk("lrclk_slots", cnt, 0);
    chk("underrun_1", underrun_cnt, 1);
    chk("loop_rx_left", rx_left, 24'hABCDEF);
    chk("loop_rx_right", rx_right, 24'h123456);
    ones = 0; prev = bclk;
    for (int i = 0; i < 256; i++) begin
      @(negedge tb_ACLK);
      if (bclk && !prev && sdata_out) ones++;
      prev = bclk;
    end
    chk("underrun_frame_zero", ones, 0);
    chk("underrun_rx_zero", rx_left, 0);
    chk("underrun_2", underrun_cnt, 2);
    tx_valid = 1;
    cyc(256);
    cnt = 0;
    for (int i = 0; i < 512; i++) begin @(negedge tb_ACLK); if (rx_valid) cnt++; end
    chk("rx_valid_per_frame", cnt, 2);
    chk("refill_rx_left", rx_left, 24'hABCDEF);
    chk("refill_rx_right", rx_right, 24'h123456);
    chk("refill_no_underrun", underrun_cnt, 2);
    loop = 0; cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      tx_left = DW'($urandom); tx_right = DW'($urandom);
      if (tx_ready) cnt++;
      @(negedge tb_ACLK);
    end
    chk("accepts_per_4_frames", cnt, 4);
    wait_bit(10);
    enable = 0;
    cyc(1);
    chk("dis_bclk", bclk, 0);
    chk("dis_lrclk", lrclk, 0);
    chk("dis_sdata", sdata_out, 0);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin @(negedge tb_ACLK); if (rx_valid) cnt++; end
    chk("dis_no_rx_valid", cnt, 0);
    chk("dis_hold_kept", tx_ready, 0);
    enable = 1;
    cyc(600);
    tx_valid = 0;
    cyc(300);
    wait_bit(10);
    enable = 0;
    cyc(1);
    chk("dis_empty_ready", tx_ready, 1);
    cyc(50);
    enable = 1;
    cyc(300);
    @(posedge tb_ACLK);
    #1 force dut.underrun_cnt = 16'hFFFE;
    m_under = 16'hFFFE;
    #1 release dut.underrun_cnt;
    cyc(600);
    chk("underrun_saturated", underrun_cnt, 16'hFFFF);
    for (int r = 0; r < 8; r++) begin
      enable = 1'($urandom); tx_valid = 1'($urandom); loop = 1'($urandom);
      for (int i = $urandom_range(20, 400); i > 0; i--) begin
        tx_left = DW'($urandom); tx_right = DW'($urandom);
        @(negedge tb_ACLK);
      end
    end
    enable = 1; tx_valid = 1;
    cyc(100);
    ARESETN = 0; enable = 0; tx_valid = 0;
    cyc(5);
    reset_checks();
    ARESETN = 1;
    cyc(6);
    chk("post_reset_bclk", bclk, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
